// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encoding, PC increment and the reset/NOP instruction word.
package mips_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DROP  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    localparam int          PC_INCR   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch stage is master, the memory is slave.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [31:0]       IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts un-acknowledged request cycles; tc flags TIMEOUT-1 reached.
// Saturates at the terminal count so it never wraps.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC -> imem req/ack -> IF/ID holding register.
// Flush discards in-flight or held work; a memory timeout is sticky.
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC,
    output logic              PCWrite,
    fetch_stage_if.master     imem,
    input  logic              Flush,
    input  logic              IdReady,
    output logic              InstrValid,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              FetchErr
);
    fetch_state_e      state;
    fetch_state_e      state_n;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic              tc;
    logic              busy;
    logic              cnt_clr;
    logic              cnt_en;
    logic              load_addr;

    assign ack  = imem.IMemAck;
    assign busy = (state == ST_REQ) || (state == ST_DROP);

    // Counter restarts whenever a request phase (REQ or DROP) is entered.
    assign cnt_clr   = (state_n != state) &&
                       ((state_n == ST_REQ) || (state_n == ST_DROP));
    assign cnt_en    = busy && !ack;
    assign load_addr = (state_n == ST_REQ) && (state != ST_REQ);

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (!Flush) state_n = ST_REQ;
            end
            ST_REQ: begin
                if (Flush)    state_n = ack ? ST_IDLE : ST_DROP;
                else if (ack) state_n = ST_HOLD;
                else if (tc)  state_n = ST_FAULT;
            end
            ST_DROP: begin
                if (ack)     state_n = ST_IDLE;
                else if (tc) state_n = ST_FAULT;
            end
            ST_HOLD: begin
                if (Flush)        state_n = ST_IDLE;
                else if (IdReady) state_n = ST_REQ;
            end
            ST_FAULT: state_n = ST_FAULT;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        imem.IMemReq = busy;
        PCWrite      = (state == ST_REQ) && ack && !Flush;
        InstrValid   = (state == ST_HOLD);
        FetchErr     = (state == ST_FAULT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr    <= '0;
            Instr   <= NOP_INSTR;
            PCPlus4 <= '0;
        end else begin
            if (load_addr) addr <= PC;
            if (PCWrite) begin
                Instr   <= imem.IMemData;
                PCPlus4 <= addr + ADDR_W'(PC_INCR);
            end
        end
    end

    assign imem.IMemAddr = addr;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of fetched words.
// A negedge monitor pops expectations whenever InstrValid rises.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic        PCWrite;
    logic        Flush;
    logic        IdReady;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] PCPlus4;
    logic        FetchErr;

    int   n_chk;
    int   n_fail;
    int   pcw_cnt;
    logic prev_valid;
    exp_t sb[$];

    fetch_stage_if #(.ADDR_W(32)) imem ();

    fetch_stage #(
        .TIMEOUT (8),
        .ADDR_W  (32)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PC         (PC),
        .PCWrite    (PCWrite),
        .imem       (imem.master),
        .Flush      (Flush),
        .IdReady    (IdReady),
        .InstrValid (InstrValid),
        .Instr      (Instr),
        .PCPlus4    (PCPlus4),
        .FetchErr   (FetchErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: compare each newly presented instruction.
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_valid = 1'b0;
        end else begin
            if (PCWrite) pcw_cnt++;
            if (InstrValid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h expected none",
                             Instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_instr", Instr, e.instr);
                    check("sb_pcplus4", PCPlus4, e.pc4);
                end
            end
            prev_valid = InstrValid;
        end
    end

    initial begin
        int n;
        n_chk         = 0;
        n_fail        = 0;
        pcw_cnt       = 0;
        prev_valid    = 1'b0;
        Reset         = 1'b0;
        PC            = 32'h0;
        Flush         = 1'b0;
        IdReady       = 1'b0;
        imem.IMemAck  = 1'b0;
        imem.IMemData = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_req", {31'd0, imem.IMemReq}, 32'd0);
        check("rst_addr", imem.IMemAddr, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pcplus4", PCPlus4, 32'h0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("rst_fetcherr", {31'd0, FetchErr}, 32'd0);

        // First fetch, memory latency 2.
        PC    = 32'h0000_0040;
        Reset = 1'b1;
        tick();
        check("req1_req", {31'd0, imem.IMemReq}, 32'd1);
        check("req1_addr", imem.IMemAddr, 32'h0000_0040);
        check("req1_nopcw", {31'd0, PCWrite}, 32'd0);
        tick();
        imem.IMemAck  = 1'b1;
        imem.IMemData = 32'h1234_5678;
        sb.push_back('{32'h1234_5678, 32'h0000_0044});
        #1;
        check("req1_pcw", {31'd0, PCWrite}, 32'd1);
        tick();
        imem.IMemAck = 1'b0;
        check("hold_valid", {31'd0, InstrValid}, 32'd1);

        // Stall in HOLD with decode not ready.
        PC = 32'h0000_0044;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", {31'd0, imem.IMemReq}, 32'd0);
            check("stall_instr", Instr, 32'h1234_5678);
            check("stall_valid", {31'd0, InstrValid}, 32'd1);
        end
        check("one_pcwrite", pcw_cnt, 32'd1);
        IdReady = 1'b1;
        tick();
        IdReady = 1'b0;
        check("req2_addr", imem.IMemAddr, 32'h0000_0044);
        check("req2_req", {31'd0, imem.IMemReq}, 32'd1);
        check("req2_valid", {31'd0, InstrValid}, 32'd0);

        // Flush during REQ, ack arrives 3 cycles later in DROP.
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("drop_req", {31'd0, imem.IMemReq}, 32'd1);
        tick();
        tick();
        imem.IMemAck  = 1'b1;
        imem.IMemData = 32'hDEAD_BEEF;
        #1;
        check("drop_nopcw", {31'd0, PCWrite}, 32'd0);
        tick();
        imem.IMemAck = 1'b0;
        check("drop_idle_req", {31'd0, imem.IMemReq}, 32'd0);
        check("drop_valid", {31'd0, InstrValid}, 32'd0);

        // Flush and ack in the same REQ cycle.
        tick();
        check("fa_req", {31'd0, imem.IMemReq}, 32'd1);
        Flush         = 1'b1;
        imem.IMemAck  = 1'b1;
        imem.IMemData = 32'hBAD0_BAD0;
        #1;
        check("fa_nopcw", {31'd0, PCWrite}, 32'd0);
        tick();
        Flush        = 1'b0;
        imem.IMemAck = 1'b0;
        check("fa_valid", {31'd0, InstrValid}, 32'd0);
        check("fa_idle", {31'd0, imem.IMemReq}, 32'd0);
        check("pcw_after_flush", pcw_cnt, 32'd1);

        // PC+4 wrap-around, latency 1.
        PC = 32'hFFFF_FFFC;
        tick();
        check("wrap_addr", imem.IMemAddr, 32'hFFFF_FFFC);
        imem.IMemAck  = 1'b1;
        imem.IMemData = 32'hCAFE_BABE;
        sb.push_back('{32'hCAFE_BABE, 32'h0000_0000});
        tick();
        imem.IMemAck = 1'b0;
        check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("hold_flush_valid", {31'd0, InstrValid}, 32'd0);

        // Timeout with no ack.
        tick();
        n = 0;
        while (imem.IMemReq && n < 20) begin
            n++;
            tick();
        end
        check("tmo_cycles", n, 32'd8);
        check("tmo_err", {31'd0, FetchErr}, 32'd1);
        check("tmo_req", {31'd0, imem.IMemReq}, 32'd0);
        repeat (5) tick();
        check("fault_req", {31'd0, imem.IMemReq}, 32'd0);
        check("fault_err", {31'd0, FetchErr}, 32'd1);
        Reset = 1'b0;
        #1;
        check("fault_rst_err", {31'd0, FetchErr}, 32'd0);

        // Asynchronous reset in the middle of DROP.
        tick();
        Reset = 1'b1;
        PC    = 32'h0000_0100;
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("drop2_req", {31'd0, imem.IMemReq}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_req", {31'd0, imem.IMemReq}, 32'd0);
        check("arst_addr", imem.IMemAddr, 32'h0);
        check("arst_instr", Instr, 32'h0);
        check("arst_pcplus4", PCPlus4, 32'h0);
        check("arst_valid", {31'd0, InstrValid}, 32'd0);
        check("arst_err", {31'd0, FetchErr}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        check("pcw_total", pcw_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
